// File: rtl/ship_life_ctl.sv
// Ship lifecycle FSM: consumes the latched hit level and sequences
// explosion, blinking invulnerable respawn and game over; emits hit-lock unlock pulses.
module ship_life_ctl #(
  parameter int LIVES_INIT   = 3,
  parameter int DEATH_FRAMES = 60,
  parameter int BLINK_FRAMES = 90,
  parameter int BLINK_BIT    = 3,
  parameter int CNT_W        = 8
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       hit_locked,
  input  logic       frame_tick,
  output logic       unlock,
  output logic       ship_visible,
  output logic       invuln,
  output logic [1:0] lives,
  output logic       game_over
);

  localparam logic [1:0] S_ALIVE   = 2'd0;
  localparam logic [1:0] S_DYING   = 2'd1;
  localparam logic [1:0] S_RESPAWN = 2'd2;
  localparam logic [1:0] S_OVER    = 2'd3;

  localparam logic [CNT_W-1:0] DEATH_LAST = CNT_W'(DEATH_FRAMES - 1);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);
  localparam logic [1:0]       LIVES_RST  = 2'(LIVES_INIT);

  logic [1:0]       state, state_n;
  logic [CNT_W-1:0] frame_cnt, cnt_n;
  logic [1:0]       guard_cnt, guard_n;
  logic [1:0]       lives_n;
  logic             unlock_n, vis_n, inv_n, go_n;

  always_comb begin
    state_n  = state;
    cnt_n    = frame_cnt;
    guard_n  = guard_cnt;
    lives_n  = lives;
    unlock_n = 1'b0;
    case (state)
      S_ALIVE: begin
        guard_n = (guard_cnt == 2'd0) ? 2'd0 : guard_cnt - 2'd1;
        // A hit outranks a coincident frame_tick; ticks are irrelevant here anyway.
        if (hit_locked && guard_cnt == 2'd0) begin
          cnt_n   = '0;
          lives_n = (lives == 2'd0) ? 2'd0 : lives - 2'd1;
          state_n = (lives <= 2'd1) ? S_OVER : S_DYING;
        end
      end
      S_DYING: begin
        if (frame_tick) begin
          if (frame_cnt == DEATH_LAST) begin
            state_n  = S_RESPAWN;
            cnt_n    = '0;
            unlock_n = 1'b1;
          end else begin
            cnt_n = frame_cnt + CNT_W'(1);
          end
        end
      end
      S_RESPAWN: begin
        if (frame_tick) begin
          if (frame_cnt == BLINK_LAST) begin
            // Guard masks the stale hit level until the hit-lock stage has cleared.
            state_n  = S_ALIVE;
            cnt_n    = '0;
            guard_n  = 2'd2;
            unlock_n = 1'b1;
          end else begin
            cnt_n = frame_cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        lives_n = 2'd0;
      end
    endcase
  end

  // Outputs are registered from next-state values so they align with the state register.
  always_comb begin
    vis_n = 1'b0;
    if (state_n == S_ALIVE)        vis_n = 1'b1;
    else if (state_n == S_RESPAWN) vis_n = ~cnt_n[BLINK_BIT];
    inv_n = (state_n != S_ALIVE) || (guard_n != 2'd0);
    go_n  = (state_n == S_OVER);
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state        <= S_ALIVE;
      frame_cnt    <= '0;
      guard_cnt    <= 2'd0;
      lives        <= LIVES_RST;
      unlock       <= 1'b0;
      ship_visible <= 1'b1;
      invuln       <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      state        <= state_n;
      frame_cnt    <= cnt_n;
      guard_cnt    <= guard_n;
      lives        <= lives_n;
      unlock       <= unlock_n;
      ship_visible <= vis_n;
      invuln       <= inv_n;
      game_over    <= go_n;
    end
  end

endmodule

// File: tb/tb_ship_life_ctl.sv
// Directed bench for ship_life_ctl with short death/blink windows so every
// transition, blink phase and the game-over path can be checked cycle by cycle.
module tb_ship_life_ctl;
  logic       pclk = 1'b0;
  logic       rst, hit_locked, frame_tick;
  logic       unlock, ship_visible, invuln, game_over;
  logic [1:0] lives;

  int n_chk  = 0;
  int n_fail = 0;

  ship_life_ctl #(
    .LIVES_INIT(3), .DEATH_FRAMES(4), .BLINK_FRAMES(6), .BLINK_BIT(1), .CNT_W(8)
  ) dut (
    .pclk(pclk), .rst(rst), .hit_locked(hit_locked), .frame_tick(frame_tick),
    .unlock(unlock), .ship_visible(ship_visible), .invuln(invuln),
    .lives(lives), .game_over(game_over)
  );

  always #5 pclk = ~pclk;

  // Drive inputs for one cycle, then sample 1 time unit after the edge.
  task automatic cyc(input logic tk, input logic ht);
    frame_tick = tk;
    hit_locked = ht;
    @(posedge pclk);
    #1;
    frame_tick = 1'b0;
  endtask

  task automatic chk(input string tag, input logic eu, input logic ev,
                     input logic ei, input logic [1:0] el, input logic eg);
    n_chk += 5;
    assert (unlock === eu) else begin
      n_fail++; $error("FAIL %s unlock got %0b want %0b", tag, unlock, eu);
    end
    assert (ship_visible === ev) else begin
      n_fail++; $error("FAIL %s ship_visible got %0b want %0b", tag, ship_visible, ev);
    end
    assert (invuln === ei) else begin
      n_fail++; $error("FAIL %s invuln got %0b want %0b", tag, invuln, ei);
    end
    assert (lives === el) else begin
      n_fail++; $error("FAIL %s lives got %0d want %0d", tag, lives, el);
    end
    assert (game_over === eg) else begin
      n_fail++; $error("FAIL %s game_over got %0b want %0b", tag, game_over, eg);
    end
  endtask

  // Visibility during respawn for blink counter 0..5 with BLINK_BIT=1.
  logic [5:0] blink_vis;

  initial begin
    blink_vis = 6'b110011;
    rst = 1'b1; hit_locked = 1'b0; frame_tick = 1'b0;
    cyc(0, 0);
    cyc(0, 0);
    chk("reset", 0, 1, 0, 2'd3, 0);
    rst = 1'b0;

    for (int i = 0; i < 100; i++) begin
      cyc(i % 10 == 9, 0);
      chk("idle", 0, 1, 0, 2'd3, 0);
    end

    // First life lost; hit level stays latched through DYING and RESPAWN.
    cyc(1, 1);
    chk("hit1", 0, 0, 1, 2'd2, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1);
      chk("dying1", 0, 0, 1, 2'd2, 0);
    end
    cyc(1, 1);
    chk("enter_resp1", 1, 1, 1, 2'd2, 0);
    cyc(0, 1);
    chk("resp1_idle", 0, 1, 1, 2'd2, 0);
    for (int i = 1; i < 6; i++) begin
      cyc(1, 1);
      chk("blink1", 0, blink_vis[i], 1, 2'd2, 0);
    end
    cyc(1, 1);
    chk("exit_resp1", 1, 1, 1, 2'd2, 0);
    cyc(0, 1);
    chk("guard1", 0, 1, 1, 2'd2, 0);
    cyc(0, 1);
    chk("guard_end1", 0, 1, 0, 2'd2, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0);
      chk("alive2", 0, 1, 0, 2'd2, 0);
    end

    // Second life lost; a fresh hit pulse during RESPAWN must be ignored.
    cyc(0, 1);
    chk("hit2", 0, 0, 1, 2'd1, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0);
      chk("dying2", 0, 0, 1, 2'd1, 0);
    end
    cyc(1, 0);
    chk("enter_resp2", 1, 1, 1, 2'd1, 0);
    cyc(0, 1);
    chk("resp2_hit", 0, 1, 1, 2'd1, 0);
    cyc(0, 0);
    chk("resp2_idle", 0, 1, 1, 2'd1, 0);
    for (int i = 1; i < 6; i++) begin
      cyc(1, 0);
      chk("blink2", 0, blink_vis[i], 1, 2'd1, 0);
    end
    cyc(1, 0);
    chk("exit_resp2", 1, 1, 1, 2'd1, 0);
    cyc(0, 0);
    chk("guard2", 0, 1, 1, 2'd1, 0);
    cyc(0, 0);
    chk("guard_end2", 0, 1, 0, 2'd1, 0);

    // Final life: hit coincident with a tick goes straight to game over.
    cyc(1, 1);
    chk("hit3", 0, 0, 1, 2'd0, 1);
    for (int i = 0; i < 50; i++) begin
      cyc(1, i[0]);
      chk("game_over", 0, 0, 1, 2'd0, 1);
    end

    rst = 1'b1;
    cyc(0, 0);
    chk("reset2", 0, 1, 0, 2'd3, 0);
    rst = 1'b0;

    // Reset mid-DYING with frame_cnt=2 and a tick pending.
    cyc(0, 1);
    chk("hit4", 0, 0, 1, 2'd2, 0);
    cyc(1, 0);
    cyc(1, 0);
    chk("dying4", 0, 0, 1, 2'd2, 0);
    rst = 1'b1;
    cyc(1, 0);
    chk("rst_mid", 0, 1, 0, 2'd3, 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0);
      chk("after_rst", 0, 1, 0, 2'd3, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
